// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA box renderer.
// Holds active-area defaults, colour constants and the mover state type.
package vga_pkg;

  localparam int H_ACT_D = 640;
  localparam int V_ACT_D = 480;

  localparam logic [23:0] BOX_RGB_D = 24'hFF0000;
  localparam logic [23:0] BG_RGB_D  = 24'h000040;
  localparam logic [23:0] GRID_RGB  = 24'h404040;

  typedef enum logic [1:0] {
    IDLE,
    UPD_X,
    UPD_Y
  } mv_state_t;

endpackage

// File: rtl/vga_box_mover.sv
// Box mover: detects the vs_in falling edge once per frame and steps the
// box position, bouncing off the active-area walls.
// Ports: clk25M, rst (sync, active-low), en, vs_in -> box_x[9:0], box_y[8:0].
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACT = H_ACT_D,
  parameter int V_ACT = V_ACT_D,
  parameter int SIZE  = 32,
  parameter int STEP  = 4
) (
  input  logic       clk25M,
  input  logic       rst,
  input  logic       en,
  input  logic       vs_in,
  output logic [9:0] box_x,
  output logic [8:0] box_y
);

  logic      vs_d;
  logic      tick;
  logic      dir_x;
  logic      dir_y;
  mv_state_t state;
  mv_state_t state_nx;

  // 11-bit sums so the STEP addition never wraps.
  logic [10:0] x_add;
  logic [10:0] y_add;
  logic [10:0] x_lim;
  logic [10:0] y_lim;

  assign tick  = vs_d & ~vs_in;
  assign x_add = {1'b0, box_x} + 11'(STEP);
  assign y_add = {2'b0, box_y} + 11'(STEP);
  assign x_lim = 11'(H_ACT - SIZE);
  assign y_lim = 11'(V_ACT - SIZE);

  always_ff @(posedge clk25M) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick && en) state_nx = UPD_X;
      UPD_X:   state_nx = UPD_Y;
      UPD_Y:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk25M) begin
    if (!rst) begin
      vs_d  <= 1'b1;
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else begin
      vs_d <= vs_in;
      if (state == UPD_X) begin
        if (dir_x) begin
          if (x_add >= x_lim) begin
            box_x <= x_lim[9:0];
            dir_x <= 1'b0;
          end else begin
            box_x <= x_add[9:0];
          end
        end else if ({1'b0, box_x} <= 11'(STEP)) begin
          box_x <= '0;
          dir_x <= 1'b1;
        end else begin
          box_x <= box_x - 10'(STEP);
        end
      end
      if (state == UPD_Y) begin
        if (dir_y) begin
          if (y_add >= y_lim) begin
            box_y <= y_lim[8:0];
            dir_y <= 1'b0;
          end else begin
            box_y <= y_add[8:0];
          end
        end else if ({2'b0, box_y} <= 11'(STEP)) begin
          box_y <= '0;
          dir_y <= 1'b1;
        end else begin
          box_y <= box_y - 9'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel colour stage: 2-cycle pipeline drawing a bouncing box, with
// sync/blank delayed to match. Optional grid background: VGA_GRID_EN.
// Ports: clk25M, rst, en, X, Y, blank_n_in, hs_in, vs_in ->
//        VGA_R/G/B, VGA_HS_O, VGA_VS_O, VGA_BLANK_N_O.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int          H_ACT   = H_ACT_D,
  parameter int          V_ACT   = V_ACT_D,
  parameter int          SIZE    = 32,
  parameter int          STEP    = 4,
  parameter logic [23:0] BOX_RGB = BOX_RGB_D,
  parameter logic [23:0] BG_RGB  = BG_RGB_D
) (
  input  logic        clk25M,
  input  logic        rst,
  input  logic        en,
  input  logic [12:0] X,
  input  logic [12:0] Y,
  input  logic        blank_n_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS_O,
  output logic        VGA_VS_O,
  output logic        VGA_BLANK_N_O
);

  logic [9:0]  box_x;
  logic [8:0]  box_y;
  logic [12:0] bx;
  logic [12:0] by;
  logic        inside_c;
  logic        in1;
  logic        bl1;
  logic        hs1;
  logic        vs1;
  logic [23:0] bg_c;
  logic [23:0] rgb_c;

  vga_box_mover #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT),
    .SIZE  (SIZE),
    .STEP  (STEP)
  ) u_mover (
    .clk25M (clk25M),
    .rst    (rst),
    .en     (en),
    .vs_in  (vs_in),
    .box_x  (box_x),
    .box_y  (box_y)
  );

  assign bx = {3'b0, box_x};
  assign by = {4'b0, box_y};

  assign inside_c = (X >= bx) && (X < bx + 13'(SIZE)) &&
                    (Y >= by) && (Y < by + 13'(SIZE));

`ifdef VGA_GRID_EN
  logic grid_c;
  logic grid1;

  assign grid_c = (X[4:0] == 5'd0) || (Y[4:0] == 5'd0);
  assign bg_c   = grid1 ? GRID_RGB : BG_RGB;
`else
  assign bg_c = BG_RGB;
`endif

  always_ff @(posedge clk25M) begin
    if (!rst) begin
      in1 <= 1'b0;
      bl1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
    end else begin
      in1 <= inside_c;
      bl1 <= blank_n_in;
      hs1 <= hs_in;
      vs1 <= vs_in;
    end
  end

`ifdef VGA_GRID_EN
  always_ff @(posedge clk25M) begin
    if (!rst) grid1 <= 1'b0;
    else      grid1 <= grid_c;
  end
`endif

  always_comb begin
    rgb_c = '0;
    if (!bl1)     rgb_c = '0;
    else if (in1) rgb_c = BOX_RGB;
    else          rgb_c = bg_c;
  end

  always_ff @(posedge clk25M) begin
    if (!rst) begin
      VGA_R         <= '0;
      VGA_G         <= '0;
      VGA_B         <= '0;
      VGA_HS_O      <= 1'b1;
      VGA_VS_O      <= 1'b1;
      VGA_BLANK_N_O <= 1'b0;
    end else begin
      VGA_R         <= rgb_c[23:16];
      VGA_G         <= rgb_c[15:8];
      VGA_B         <= rgb_c[7:0];
      VGA_HS_O      <= hs1;
      VGA_VS_O      <= vs1;
      VGA_BLANK_N_O <= bl1;
    end
  end

endmodule

// File: tb/tb_vga_box_renderer.sv
// Self-checking bench for vga_box_renderer: scoreboard of expected pixels
// against a reference box-motion model.
module tb_vga_box_renderer;

  logic        clk25M = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [12:0] X = '0;
  logic [12:0] Y = '0;
  logic        blank_n_in = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS_O, VGA_VS_O, VGA_BLANK_N_O;

  vga_box_renderer dut (
    .clk25M        (clk25M),
    .rst           (rst),
    .en            (en),
    .X             (X),
    .Y             (Y),
    .blank_n_in    (blank_n_in),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .VGA_R         (VGA_R),
    .VGA_G         (VGA_G),
    .VGA_B         (VGA_B),
    .VGA_HS_O      (VGA_HS_O),
    .VGA_VS_O      (VGA_VS_O),
    .VGA_BLANK_N_O (VGA_BLANK_N_O)
  );

  always #20 clk25M = ~clk25M;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model of box motion
  int mx = 0, my = 0;
  bit dx = 1, dy = 1;

  always @(posedge clk25M) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk25M) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, "_due"}, 32'(e.due), 32'(cyc));
      chk({e.tag, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e.rgb});
      chk({e.tag, "_hs"}, 32'(VGA_HS_O), 32'(e.hs));
      chk({e.tag, "_vs"}, 32'(VGA_VS_O), 32'(e.vs));
      chk({e.tag, "_bl"}, 32'(VGA_BLANK_N_O), 32'(e.bl));
    end
  end

  function automatic logic [23:0] exp_rgb(int x, int y, bit b);
    if (!b) return 24'h0;
    if (x >= mx && x < mx + 32 && y >= my && y < my + 32)
      return 24'hFF0000;
`ifdef VGA_GRID_EN
    if ((x % 32) == 0 || (y % 32) == 0) return 24'h404040;
`endif
    return 24'h000040;
  endfunction

  function automatic void model_step();
    if (dx) begin
      if (mx + 4 >= 608) begin mx = 608; dx = 0; end
      else mx = mx + 4;
    end else begin
      if (mx <= 4) begin mx = 0; dx = 1; end
      else mx = mx - 4;
    end
    if (dy) begin
      if (my + 4 >= 448) begin my = 448; dy = 0; end
      else my = my + 4;
    end else begin
      if (my <= 4) begin my = 0; dy = 1; end
      else my = my - 4;
    end
  endfunction

  task automatic pix(input string tag, input int x, input int y,
                     input bit b, input bit hs);
    exp_t e;
    @(posedge clk25M);
    #1;
    X = 13'(x);
    Y = 13'(y);
    blank_n_in = b;
    hs_in = hs;
    e.due = cyc + 2;
    e.rgb = exp_rgb(x, y, b);
    e.hs = hs;
    e.vs = vs_in;
    e.bl = b;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk25M);
      n++;
    end
    @(negedge clk25M);
    chk("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic tick();
    @(posedge clk25M);
    #1;
    blank_n_in = 1'b0;
    vs_in = 1'b0;
    if (en) model_step();
    repeat (3) @(posedge clk25M);
    #1;
    vs_in = 1'b1;
    repeat (2) @(posedge clk25M);
  endtask

  task automatic chk_box(input string tag);
    @(negedge clk25M);
    chk({tag, "_x"}, 32'(dut.box_x), 32'(mx));
    chk({tag, "_y"}, 32'(dut.box_y), 32'(my));
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    repeat (3) @(posedge clk25M);
    @(negedge clk25M);
    chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_hs", 32'(VGA_HS_O), 32'd1);
    chk("rst_vs", 32'(VGA_VS_O), 32'd1);
    chk("rst_bl", 32'(VGA_BLANK_N_O), 32'd0);
    chk_box("rst_box");

    @(posedge clk25M);
    #1;
    rst = 1'b1;

    pix("lat", 5, 5, 1, 1);
    pix("hs_lo", 5, 5, 1, 0);
    pix("hs_hi", 100, 100, 1, 1);
    pix("corner", 31, 31, 1, 1);
    pix("edge_x", 32, 0, 1, 1);
    pix("edge_y", 0, 32, 1, 1);
    pix("blank", 5, 5, 0, 1);
    pix("grid", 32, 100, 1, 1);
    pix("plain", 33, 101, 1, 1);
    drain();

    en = 1'b1;
    repeat (3) tick();
    chk_box("mv3");
    en = 1'b0;
    tick();
    chk_box("frozen");
    pix("mv_in", 12, 12, 1, 1);
    pix("mv_out", 11, 12, 1, 1);
    pix("mv_end", 43, 43, 1, 1);
    pix("mv_past", 44, 43, 1, 1);
    drain();

    en = 1'b1;
    guard = 0;
    while (mx != 608 && guard < 400) begin
      tick();
      guard++;
    end
    chk("bounce_guard", 32'(guard < 400), 32'd1);
    chk_box("wall");
    pix("wall_in", 639, my, 1, 1);
    pix("wall_out", 607, my, 1, 1);
    drain();
    tick();
    chk_box("back");
    chk("back_x", 32'(mx), 32'd604);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
